// File: rtl/ofm_pkg.sv
// Shared types and defaults for the output feature-map drain path.
// The drain reads packed partial-sum words out of the OFM RAM.
package ofm_pkg;

  localparam int OFM_ADDR_W = 16;
  localparam int OFM_DATA_W = 64;
  localparam int OFM_CNT_W  = 16;
  localparam int LANE_W     = 16;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } ofm_state_e;

endpackage

// File: rtl/ofm_drain_if.sv
// Valid/ready word stream from the OFM drain toward the comparator/host path.
interface ofm_drain_if #(
  parameter int DATA_W = ofm_pkg::OFM_DATA_W
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/ofm_drain_fifo2.sv
// Two-entry first-word-fall-through buffer that absorbs the RAM read latency.
// Entry 0 is always the head; entry 1 only holds data when two words are queued.
module drain_fifo2
  import ofm_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem0_q, mem0_d;
  logic [DATA_W-1:0] mem1_q, mem1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = push_data;
        else                 mem1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the depth; the new word lands behind any survivor.
        if (count_q == 2'd1) begin
          mem0_d = push_data;
        end else begin
          mem0_d = mem1_q;
          mem1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign count = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count_q == 2'd0));

endmodule

// File: rtl/ofm_drain.sv
// Port-B unloader for the output feature-map RAM: on start it reads a word range
// and streams it out, throttling reads so the 2-entry buffer never overflows.
module ofm_drain
  import ofm_pkg::*;
#(
  parameter int ADDR_W = OFM_ADDR_W,
  parameter int DATA_W = OFM_DATA_W,
  parameter int CNT_W  = OFM_CNT_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  ofm_drain_if.master       m,
  output logic              busy,
  output logic              done
);

  ofm_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  popped_q;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              issue;
  logic              last;
  logic [2:0]        occ;

  drain_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign m.m_valid = (fifo_count != 2'd0);
  assign m.m_data  = fifo_head;
  assign last      = m.m_valid && (popped_q == num_q - CNT_W'(1));
  assign m.m_last  = last;
  assign pop       = m.m_valid && m.m_ready;

  // Words already committed to the buffer after this cycle's pop; a same-cycle
  // pop frees a slot so reads resume without a bubble when m_ready returns.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (issued_q < num_q) && (occ <= 3'd1);

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q   <= base_addr;
            num_q    <= num_words;
            issued_q <= '0;
            popped_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= (num_words == '0) ? FINISH : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr_q   <= addr_q + ADDR_W'(1);
            issued_q <= issued_q + CNT_W'(1);
          end
          if (pop) begin
            popped_q <= popped_q + CNT_W'(1);
            if (last) begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          // A zero-length drain arrives here with done still low and raises it one cycle later.
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_cfg: assert property (@(posedge clk) (RD_LAT == 1) && (DATA_W == LANE_W * LANES));

endmodule

// File: tb/tb_ofm_drain.sv
// Directed bench for ofm_drain: table-driven cycle vectors plus hand-written
// sequences for backpressure, restart-while-busy and reset mid-drain.
module tb_ofm_drain;
  import ofm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_words;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data = '0;
  logic        busy;
  logic        done;

  ofm_drain_if #(.DATA_W(64)) m ();

  ofm_drain #(.ADDR_W(16), .DATA_W(64), .CNT_W(16), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m         (m),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ramWord(input logic [15:0] a);
    return {a, a, a, a};
  endfunction

  // One-cycle-latency RAM whose word at address a is a replicated in all lanes.
  always @(posedge clk) begin
    if (rd_en) rd_data <= ramWord(rd_addr);
  end

  typedef struct {
    logic        ready;
    logic        rdEn;
    logic [15:0] addr;
    logic        valid;
    logic [63:0] data;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tab[16];
  int   tabLen;
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic [15:0] a,
                              input logic v, input logic [63:0] d, input logic l,
                              input logic b, input logic dn);
    vec_t x;
    x.ready = r; x.rdEn = e; x.addr = a; x.valid = v;
    x.data = d;  x.last = l; x.busy = b; x.done = dn;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m.m_ready = v.ready;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check({tag, " rd_en"}, 64'(rd_en), 64'(v.rdEn));
    if (v.rdEn) check({tag, " rd_addr"}, 64'(rd_addr), 64'(v.addr));
    check({tag, " m_valid"}, 64'(m.m_valid), 64'(v.valid));
    if (v.valid) check({tag, " m_data"}, m.m_data, v.data);
    check({tag, " m_last"}, 64'(m.m_last), 64'(v.last));
    check({tag, " busy"}, 64'(busy), 64'(v.busy));
    check({tag, " done"}, 64'(done), 64'(v.done));
  endtask

  // Entered just after a rising edge; leaves just after the edge that starts cycle 1.
  task automatic startDrain(input logic [15:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < tabLen; i++) begin
      applyStimulus(tab[i]);
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, i + 1), tab[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " rd_en"},   64'(rd_en),     64'd0);
    check({tag, " rd_addr"}, 64'(rd_addr),   64'd0);
    check({tag, " m_valid"}, 64'(m.m_valid), 64'd0);
    check({tag, " m_data"},  m.m_data,       64'd0);
    check({tag, " m_last"},  64'(m.m_last),  64'd0);
    check({tag, " busy"},    64'(busy),      64'd0);
    check({tag, " done"},    64'(done),      64'd0);
  endtask

  initial begin
    logic pat[6];
    int   got, reads, dones;
    logic finished, prevStall, prevLast;
    logic [63:0] prevData;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; m.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic drain");
    startDrain(16'h0010, 16'd4);
    tabLen = 8;
    tab[0] = mk(1, 1, 16'h0010, 0, 64'h0, 0, 1, 0);
    tab[1] = mk(1, 1, 16'h0011, 0, 64'h0, 0, 1, 0);
    tab[2] = mk(1, 1, 16'h0012, 1, ramWord(16'h0010), 0, 1, 0);
    tab[3] = mk(1, 1, 16'h0013, 1, ramWord(16'h0011), 0, 1, 0);
    tab[4] = mk(1, 0, 16'h0000, 1, ramWord(16'h0012), 0, 1, 0);
    tab[5] = mk(1, 0, 16'h0000, 1, ramWord(16'h0013), 1, 1, 0);
    tab[6] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 1);
    tab[7] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 0);
    runTable("basic");

    $display("[TB] zero length");
    startDrain(16'h0050, 16'd0);
    tabLen = 3;
    tab[0] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 1, 0);
    tab[1] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 1);
    tab[2] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 0);
    runTable("zero");

    $display("[TB] address wrap");
    startDrain(16'hFFFE, 16'd3);
    tabLen = 7;
    tab[0] = mk(1, 1, 16'hFFFE, 0, 64'h0, 0, 1, 0);
    tab[1] = mk(1, 1, 16'hFFFF, 0, 64'h0, 0, 1, 0);
    tab[2] = mk(1, 1, 16'h0000, 1, ramWord(16'hFFFE), 0, 1, 0);
    tab[3] = mk(1, 0, 16'h0000, 1, ramWord(16'hFFFF), 0, 1, 0);
    tab[4] = mk(1, 0, 16'h0000, 1, ramWord(16'h0000), 1, 1, 0);
    tab[5] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 1);
    tab[6] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 0);
    runTable("wrap");

    $display("[TB] backpressure");
    startDrain(16'h0020, 16'd6);
    got = 0; reads = 0; dones = 0; finished = 1'b0;
    prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
    for (int k = 1; k <= 60 && !finished; k++) begin
      m.m_ready = pat[(k - 1) % 6];
      @(negedge clk);
      if (prevStall) begin
        check($sformatf("bp c%0d held valid", k), 64'(m.m_valid), 64'd1);
        check($sformatf("bp c%0d held data", k), m.m_data, prevData);
        check($sformatf("bp c%0d held last", k), 64'(m.m_last), 64'(prevLast));
      end
      if (rd_en) reads++;
      if (m.m_valid && m.m_ready) begin
        check($sformatf("bp word%0d data", got), m.m_data, ramWord(16'(16'h0020 + got)));
        check($sformatf("bp word%0d last", got), 64'(m.m_last), 64'(got == 5));
        got++;
      end
      check($sformatf("bp c%0d outstanding", k), 64'((reads - got) <= 2), 64'd1);
      if (done) begin
        dones++;
        finished = 1'b1;
      end
      prevStall = m.m_valid && !m.m_ready;
      prevData  = m.m_data;
      prevLast  = m.m_last;
      @(posedge clk); #1;
    end
    check("bp finished in budget", 64'(finished), 64'd1);
    check("bp word count", 64'(got), 64'd6);
    check("bp done count", 64'(dones), 64'd1);
    m.m_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] start while busy");
    startDrain(16'h0040, 16'd5);
    got = 0; dones = 0;
    for (int k = 1; k <= 20; k++) begin
      m.m_ready = 1'b1;
      start = (k == 2);
      base_addr = 16'h0080;
      num_words = 16'd9;
      @(negedge clk);
      if (m.m_valid && m.m_ready) begin
        check($sformatf("busy word%0d data", got), m.m_data, ramWord(16'(16'h0040 + got)));
        got++;
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy word count", 64'(got), 64'd5);
    check("busy done count", 64'(dones), 64'd1);
    check("busy idle after", 64'(busy), 64'd0);

    $display("[TB] reset mid-drain");
    m.m_ready = 1'b0;
    startDrain(16'h0100, 16'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid c3 valid", 64'(m.m_valid), 64'd1);
    check("rstmid c3 busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("rstmid c4");
    for (int k = 5; k <= 7; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("rstmid c%0d valid", k), 64'(m.m_valid), 64'd0);
      check($sformatf("rstmid c%0d done", k), 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    startDrain(16'h0200, 16'd2);
    tabLen = 6;
    tab[0] = mk(1, 1, 16'h0200, 0, 64'h0, 0, 1, 0);
    tab[1] = mk(1, 1, 16'h0201, 0, 64'h0, 0, 1, 0);
    tab[2] = mk(1, 0, 16'h0000, 1, ramWord(16'h0200), 0, 1, 0);
    tab[3] = mk(1, 0, 16'h0000, 1, ramWord(16'h0201), 1, 1, 0);
    tab[4] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 1);
    tab[5] = mk(1, 0, 16'h0000, 0, 64'h0, 0, 0, 0);
    runTable("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
